// File: rtl/cdu_pkg.sv
// Shared definitions for the count pulse transmitter: FSM state encoding,
// default pulse/gap timing and a small constant helper for sizing the timer.
package cdu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } cdu_state_e;

    localparam int CDU_PULSE_W_DEF = 4;
    localparam int CDU_GAP_W_DEF   = 4;

    // Larger of two integers, used to size the shared pulse/gap timer.
    function automatic int cdu_max(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/count_pulse_tx_if.sv
// Delta handshake between a count producer and the pulse transmitter.
// The producer offers a signed increment with delta_valid; the transfer
// happens on an edge where delta_valid and delta_ready are both high.
interface count_pulse_tx_if #(
    parameter int CNT_W = 15
) ();

    logic                    delta_valid;
    logic signed [CNT_W-1:0] delta;
    logic                    delta_ready;

    modport master (
        output delta_valid,
        output delta,
        input  delta_ready
    );

    modport slave (
        input  delta_valid,
        input  delta,
        output delta_ready
    );

endinterface

// File: rtl/count_pulse_tx.sv
// Count pulse transmitter: accumulates signed count deltas and replays them
// as fixed-width +1/-1 pulses toward an AGC counter cell. Each pulse is held
// PULSE_W clocks and followed by at least GAP_W low clocks. The accumulator
// saturates symmetrically and raises a sticky overflow flag.
module count_pulse_tx
    import cdu_pkg::*;
#(
    parameter int PULSE_W = CDU_PULSE_W_DEF,
    parameter int GAP_W   = CDU_GAP_W_DEF,
    parameter int CNT_W   = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    count_pulse_tx_if.slave         dif,
    input  logic                    ovf_clr,
    output logic                    plus_pulse,
    output logic                    minus_pulse,
    output logic                    busy,
    output logic signed [CNT_W-1:0] pending,
    output logic                    overflow
);

    localparam int TMR_MAX = cdu_max(PULSE_W, GAP_W);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_W - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

    // Saturation bounds are symmetric: the most negative code is never used.
    localparam logic signed [CNT_W:0] SAT_POS = $signed({2'b00, {(CNT_W-1){1'b1}}});
    localparam logic signed [CNT_W:0] SAT_NEG = -SAT_POS;
    localparam logic signed [CNT_W:0] STEP_UP = (CNT_W+1)'(1);

    cdu_state_e              state_q, state_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic signed [CNT_W-1:0] pending_q, pending_d;
    logic                    overflow_q, overflow_d;
    logic                    plus_q, plus_d;
    logic                    minus_q, minus_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;

    logic                    start_s;
    logic                    neg_s;
    logic                    accept_s;
    logic                    sat_s;
    logic signed [CNT_W:0]   pend_ext_s;
    logic signed [CNT_W:0]   delta_ext_s;
    logic signed [CNT_W:0]   step_s;
    logic signed [CNT_W:0]   sum_s;

    // A pulse starts from IDLE, or at the end of a gap, whenever counts remain.
    assign start_s  = (pending_q != '0) &&
                      ((state_q == ST_IDLE) || ((state_q == ST_GAP) && (timer_q == '0)));
    // Pulse polarity comes from pending at the start edge only.
    assign neg_s    = pending_q[CNT_W-1];
    assign accept_s = dif.delta_valid && ready_q;

    // Next-state, timer and pulse-line logic of the IDLE/PULSE/GAP sequencer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        plus_d  = plus_q;
        minus_d = minus_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_PULSE;
                    timer_d = PULSE_LOAD;
                    plus_d  = ~neg_s;
                    minus_d = neg_s;
                end else begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    plus_d  = 1'b0;
                    minus_d = 1'b0;
                end
            end
            ST_PULSE: begin
                if (timer_q == '0) begin
                    state_d = ST_GAP;
                    timer_d = GAP_LOAD;
                    plus_d  = 1'b0;
                    minus_d = 1'b0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            ST_GAP: begin
                if (timer_q == '0) begin
                    if (start_s) begin
                        state_d = ST_PULSE;
                        timer_d = PULSE_LOAD;
                        plus_d  = ~neg_s;
                        minus_d = neg_s;
                    end else begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                plus_d  = 1'b0;
                minus_d = 1'b0;
            end
        endcase
    end

    // Accumulator update: add accepted delta, remove the unit just emitted,
    // clamp symmetrically and keep overflow sticky (set beats clear).
    always_comb begin
        pend_ext_s = {pending_q[CNT_W-1], pending_q};
        if (accept_s) begin
            delta_ext_s = {dif.delta[CNT_W-1], dif.delta};
        end else begin
            delta_ext_s = '0;
        end
        if (!start_s) begin
            step_s = '0;
        end else if (neg_s) begin
            step_s = -STEP_UP;
        end else begin
            step_s = STEP_UP;
        end
        sum_s = pend_ext_s + delta_ext_s - step_s;
        if (sum_s > SAT_POS) begin
            pending_d = SAT_POS[CNT_W-1:0];
            sat_s     = 1'b1;
        end else if (sum_s < SAT_NEG) begin
            pending_d = SAT_NEG[CNT_W-1:0];
            sat_s     = 1'b1;
        end else begin
            pending_d = sum_s[CNT_W-1:0];
            sat_s     = 1'b0;
        end
        if (sat_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Status flags registered from next-state values so they line up with state.
    always_comb begin
        busy_d  = (state_d != ST_IDLE) || (pending_d != '0);
        ready_d = (state_d != ST_PULSE);
    end

    // State, timer, accumulator and output flops; reset dominates all inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            plus_q     <= 1'b0;
            minus_q    <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            plus_q     <= plus_d;
            minus_q    <= minus_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign dif.delta_ready = ready_q;
    assign plus_pulse      = plus_q;
    assign minus_pulse     = minus_q;
    assign busy            = busy_q;
    assign pending         = pending_q;
    assign overflow        = overflow_q;

endmodule

// File: doc/count_pulse_tx.md
COUNT_PULSE_TX -- requirements
Module: count_pulse_tx

Interface
REQ-001 SHALL have parameter PULSE_W, default 4, meaning clocks each count pulse is held high (>=1).
REQ-002 SHALL have parameter GAP_W, default 4, meaning minimum low clocks after each pulse (>=1).
REQ-003 SHALL have parameter CNT_W, default 15, meaning width of delta and pending accumulator, two's complement.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port delta_valid  input  1  delta offered this cycle.
REQ-007 SHALL have port delta  input  CNT_W  signed count increment.
REQ-008 SHALL have port delta_ready  output  1  delta accepted when valid and ready both high.
REQ-009 SHALL have port ovf_clr  input  1  clears sticky overflow.
REQ-010 SHALL have port plus_pulse  output  1  registered +1 count pulse toward AGC counter cell.
REQ-011 SHALL have port minus_pulse  output  1  registered -1 count pulse.
REQ-012 SHALL have port busy  output  1  high when state != IDLE or pending != 0.
REQ-013 SHALL have port pending  output  CNT_W  signed counts not yet emitted.
REQ-014 SHALL have port overflow  output  1  sticky saturation flag.

Function
REQ-015 SHALL implement FSM states IDLE, PULSE, GAP with a down-counting timer sized for max(PULSE_W, GAP_W).
REQ-016 IDLE: if pending != 0 at edge, SHALL enter PULSE, set timer PULSE_W-1, assert plus_pulse if pending>0 else minus_pulse, step pending one toward zero.
REQ-017 PULSE: SHALL hold the asserted pulse line; at timer 0 SHALL enter GAP, drop both lines, set timer GAP_W-1.
REQ-018 GAP: at timer 0 SHALL enter PULSE per REQ-016 if pending != 0, else IDLE; sustained period therefore PULSE_W+GAP_W clocks.
REQ-019 plus_pulse and minus_pulse SHALL never be high simultaneously and each pulse SHALL be exactly PULSE_W clocks high.
REQ-020 delta_ready SHALL equal (state != PULSE); deltas SHALL be refused while a pulse is high.
REQ-021 On acceptance, pending_next SHALL be sat(pending + delta - step), step being the REQ-016 unit taken that same edge (0 otherwise), computed at CNT_W+1 bits.
REQ-022 Saturation SHALL clamp symmetric to +/-(2^(CNT_W-1)-1) and set overflow; overflow SHALL clear only on ovf_clr or reset; simultaneous set and clr SHALL leave it set.
REQ-023 Pulse sign SHALL be taken from pending at the pulse start edge; a delta changing pending's sign mid-train SHALL affect only later pulses.
REQ-024 Latency: delta_valid in cycle N (IDLE, pending 0) SHALL produce pulse line high from cycle N+2.
REQ-025 delta of 0 SHALL be accepted with no state change.

Reset
REQ-026 With rst_n low at an edge: state IDLE, timer 0, pending 0, overflow 0, plus_pulse 0, minus_pulse 0, busy 0, delta_ready 1; reset mid-pulse SHALL truncate the pulse next edge.
REQ-027 Reset SHALL take priority over delta_valid and ovf_clr.

Structure
REQ-028 Shared package cdu_pkg SHALL hold the FSM state encoding and default pulse timing constants; counts per pulse stay local.
REQ-029 No sub-module is required; timer and accumulator SHALL be inline in count_pulse_tx.

Verification (PULSE_W=4, GAP_W=4, CNT_W=15)
REQ-030 delta=+3 once -> three plus pulses, 4 high/4 low, first high 2 cycles after valid; minus_pulse never high; busy falls after last gap.
REQ-031 delta=-2, then +5 during first GAP -> one minus pulse, pending -1+5=+4, then four plus pulses.
REQ-032 pending=16383, delta=+10 -> pending 16383, overflow=1; ovf_clr pulse -> overflow=0.
REQ-033 delta_valid held from PULSE cycle 1 -> delta_ready=0 for 4 cycles, acceptance on first GAP cycle.
REQ-034 rst_n low one cycle during PULSE cycle 2 -> both pulse lines 0, pending 0, IDLE, delta_ready 1 next cycle.
REQ-035 delta=0 accepted -> no pulse, busy stays 0.
